qspi_sram_arb: RTL and testbench

QSPI_SRAM_ARB -- requirements
Module: qspi_sram_arb

---
 rtl/qspi_sram_arb_if.sv | 16 +
 rtl/qspi_sram_arb.sv | 72 +++++++
 tb/tb_qspi_sram_arb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_sram_arb_if.sv
// Simple request/ready bus shared by both masters and the QSPI SRAM controller.
// Address phase completes on an edge with req & rdy; the data phase follows.
interface qspi_sram_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rdy;
    logic [DATA_W-1:0] rdata;

    modport master (output req, write, addr, wdata, input rdy, rdata);
    modport slave  (input req, write, addr, wdata, output rdy, rdata);
endinterface

// File: rtl/qspi_sram_arb.sv
// Two-master arbiter for a pipelined QSPI SRAM bus: sticky grant with implicit
// round-robin, zero added latency, and read-data steering by data-phase owner.
module qspi_sram_arb #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   res_n,
    qspi_sram_arb_if.slave         m0,
    qspi_sram_arb_if.slave         m1,
    qspi_sram_arb_if.master        s,
    output logic [1:0]             dp_owner
);
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;

    master_t           last;
    master_t           dp_master;
    logic              dp_valid;
    logic              dp_write;

    master_t           sel;
    logic              sel_valid;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // A tie keeps the bus with LAST only while it is streaming (data phase in
    // flight); a tie arriving from idle goes to the other master.
    always_comb begin
        sel       = M0;
        sel_valid = 1'b1;
        if (m0.req && m1.req) begin
            if (dp_valid) sel = last;
            else          sel = (last == M0) ? M1 : M0;
        end else if (m1.req) begin
            sel = M1;
        end else if (!m0.req) begin
            sel_valid = 1'b0;
        end
    end

    always_comb begin
        addr_mux  = (sel == M1) ? m1.addr  : m0.addr;
        wdata_mux = (sel == M1) ? m1.wdata : m0.wdata;
        s.req     = sel_valid;
        s.write   = (sel == M1) ? m1.write : m0.write;
        s.addr    = addr_mux;
        s.wdata   = wdata_mux;
    end

    always_comb begin
        m0.rdy   = s.rdy & ~(m0.req & ~(sel_valid & (sel == M0)));
        m1.rdy   = s.rdy & ~(m1.req & ~(sel_valid & (sel == M1)));
        m0.rdata = (dp_valid && !dp_write && dp_master == M0) ? s.rdata : '0;
        m1.rdata = (dp_valid && !dp_write && dp_master == M1) ? s.rdata : '0;
        dp_owner = 2'b00;
        if (dp_valid) dp_owner = (dp_master == M1) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            last      <= M1;
            dp_valid  <= 1'b0;
            dp_master <= M0;
            dp_write  <= 1'b0;
        end else if (s.rdy) begin
            if (s.req) last <= sel;
            dp_valid  <= s.req;
            dp_master <= sel;
            dp_write  <= s.write;
        end
    end
endmodule

// File: tb/tb_qspi_sram_arb.sv
// Self-checking bench for qspi_sram_arb: directed scenarios plus an accept-order scoreboard.
module tb_qspi_sram_arb;
    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic sram_rdy = 1'b1;
    logic [1:0] dp_owner;

    int checks = 0;
    int fails = 0;

    typedef struct packed {
        logic        master;
        logic        write;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } acc_t;
    acc_t exp_q[$];

    qspi_sram_arb_if #(.ADDR_W(16), .DATA_W(8)) m0_bus ();
    qspi_sram_arb_if #(.ADDR_W(16), .DATA_W(8)) m1_bus ();
    qspi_sram_arb_if #(.ADDR_W(16), .DATA_W(8)) s_bus ();

    qspi_sram_arb #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk      (clk),
        .res_n    (res_n),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .dp_owner (dp_owner)
    );

    always #5 clk = ~clk;

    // SRAM model: read data is the low address nibble repeated (0x8006 -> 0x66).
    logic [15:0] sram_dp_addr;
    logic        sram_dp_rd;
    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sram_dp_addr <= '0;
            sram_dp_rd   <= 1'b0;
        end else if (sram_rdy) begin
            sram_dp_addr <= s_bus.addr;
            sram_dp_rd   <= s_bus.req & ~s_bus.write;
        end
    end
    assign s_bus.rdy   = sram_rdy;
    assign s_bus.rdata = sram_dp_rd ? {sram_dp_addr[3:0], sram_dp_addr[3:0]} : 8'h00;

    function automatic logic [7:0] data_of(input logic [15:0] a);
        return {a[3:0], a[3:0]};
    endfunction

    // Scoreboard: every accepted address phase must match the next expected one.
    always @(negedge clk) begin
        if (res_n && s_bus.req && s_bus.rdy) begin
            acc_t act;
            acc_t e;
            act.master = m1_bus.req & m1_bus.rdy;
            act.write  = s_bus.write;
            act.addr   = s_bus.addr;
            act.wdata  = s_bus.wdata;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL accept_unexpected: got %h expected none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL accept_order: got %h expected %h", act, e);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic drive_m0(input logic req, input logic wr, input logic [15:0] a, input logic [7:0] d);
        m0_bus.req = req; m0_bus.write = wr; m0_bus.addr = a; m0_bus.wdata = d;
        if (req) exp_q.push_back({1'b0, wr, a, d});
    endtask

    task automatic drive_m1(input logic req, input logic wr, input logic [15:0] a, input logic [7:0] d, input logic push);
        m1_bus.req = req; m1_bus.write = wr; m1_bus.addr = a; m1_bus.wdata = d;
        if (req && push) exp_q.push_back({1'b1, wr, a, d});
    endtask

    task automatic idle_all;
        drive_m0(1'b0, 1'b0, 16'h0000, 8'h00);
        drive_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic test_reset;
        res_n = 1'b0;
        idle_all();
        #3;
        checks++; if (dp_owner !== 2'b00) begin fails++; $display("FAIL reset_owner: got %b expected 00", dp_owner); end
        checks++; if (m0_bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_m0_rdata: got %h expected 00", m0_bus.rdata); end
        checks++; if (m1_bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_m1_rdata: got %h expected 00", m1_bus.rdata); end
        checks++; if (s_bus.req !== 1'b0) begin fails++; $display("FAIL reset_s_req: got %b expected 0", s_bus.req); end
        step(); step();
        res_n = 1'b1;
        step();
    endtask

    task automatic test_m0_writes;
        drive_m0(1'b1, 1'b1, 16'h0000, 8'h00);
        sample();
        checks++; if (s_bus.addr !== 16'h0000) begin fails++; $display("FAIL wr_addr0: got %h expected 0000", s_bus.addr); end
        checks++; if (m1_bus.rdy !== s_bus.rdy) begin fails++; $display("FAIL wr_m1_rdy: got %b expected %b", m1_bus.rdy, s_bus.rdy); end
        step();
        drive_m0(1'b1, 1'b1, 16'h0001, 8'h11);
        sample();
        checks++; if (s_bus.addr !== 16'h0001) begin fails++; $display("FAIL wr_addr1: got %h expected 0001", s_bus.addr); end
        checks++; if (dp_owner !== 2'b01) begin fails++; $display("FAIL wr_owner0: got %b expected 01", dp_owner); end
        step();
        idle_all();
        sample();
        checks++; if (dp_owner !== 2'b01) begin fails++; $display("FAIL wr_owner1: got %b expected 01", dp_owner); end
        checks++; if (m0_bus.rdata !== 8'h00) begin fails++; $display("FAIL wr_no_rdata: got %h expected 00", m0_bus.rdata); end
        step();
        sample();
        checks++; if (dp_owner !== 2'b00) begin fails++; $display("FAIL wr_owner_idle: got %b expected 00", dp_owner); end
        step();
    endtask

    task automatic test_tie_from_reset;
        res_n = 1'b0;
        step();
        res_n = 1'b1;
        step();
        drive_m0(1'b1, 1'b0, 16'h8001, 8'h00);
        drive_m1(1'b1, 1'b1, 16'h8002, 8'h22, 1'b1);
        sample();
        checks++; if (s_bus.addr !== 16'h8001) begin fails++; $display("FAIL tie_addr: got %h expected 8001", s_bus.addr); end
        checks++; if (m1_bus.rdy !== 1'b0) begin fails++; $display("FAIL tie_m1_stall: got %b expected 0", m1_bus.rdy); end
        checks++; if (m0_bus.rdy !== 1'b1) begin fails++; $display("FAIL tie_m0_rdy: got %b expected 1", m0_bus.rdy); end
        step();
        drive_m0(1'b0, 1'b0, 16'h0000, 8'h00);
        sample();
        checks++; if (s_bus.req !== 1'b1 || s_bus.addr !== 16'h8002) begin fails++; $display("FAIL tie_second: got req=%b addr=%h expected req=1 addr=8002", s_bus.req, s_bus.addr); end
        checks++; if (m1_bus.rdy !== 1'b1) begin fails++; $display("FAIL tie_m1_rdy: got %b expected 1", m1_bus.rdy); end
        checks++; if (m0_bus.rdata !== data_of(16'h8001)) begin fails++; $display("FAIL tie_m0_rdata: got %h expected %h", m0_bus.rdata, data_of(16'h8001)); end
        step();
        idle_all();
        sample();
        checks++; if (dp_owner !== 2'b10) begin fails++; $display("FAIL tie_owner: got %b expected 10", dp_owner); end
        checks++; if (m1_bus.rdata !== 8'h00) begin fails++; $display("FAIL tie_m1_wr_rdata: got %h expected 00", m1_bus.rdata); end
        step();
    endtask

    task automatic test_read_overlap;
        drive_m1(1'b1, 1'b0, 16'h8006, 8'h00, 1'b1);
        step();
        drive_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        drive_m0(1'b1, 1'b0, 16'h0003, 8'h00);
        sample();
        checks++; if (m1_bus.rdata !== 8'h66) begin fails++; $display("FAIL ovl_m1_rdata: got %h expected 66", m1_bus.rdata); end
        checks++; if (m0_bus.rdata !== 8'h00) begin fails++; $display("FAIL ovl_m0_rdata: got %h expected 00", m0_bus.rdata); end
        checks++; if (s_bus.addr !== 16'h0003 || m0_bus.rdy !== 1'b1) begin fails++; $display("FAIL ovl_m0_accept: got addr=%h rdy=%b expected addr=0003 rdy=1", s_bus.addr, m0_bus.rdy); end
        step();
        idle_all();
        sample();
        checks++; if (m0_bus.rdata !== 8'h33) begin fails++; $display("FAIL ovl_m0_rdata2: got %h expected 33", m0_bus.rdata); end
        step();
    endtask

    task automatic test_stream;
        for (int i = 0; i < 4; i++) begin
            drive_m0(1'b1, 1'b0, 16'h0010 + 16'(i), 8'h00);
            if (i > 0) drive_m1(1'b1, 1'b0, 16'h002C, 8'h00, 1'b0);
            sample();
            checks++; if (s_bus.addr !== 16'h0010 + 16'(i)) begin fails++; $display("FAIL stream_addr%0d: got %h expected %h", i, s_bus.addr, 16'h0010 + 16'(i)); end
            if (i > 0) begin
                checks++; if (m1_bus.rdy !== 1'b0) begin fails++; $display("FAIL stream_m1_stall%0d: got %b expected 0", i, m1_bus.rdy); end
                checks++; if (m0_bus.rdata !== data_of(16'h0010 + 16'(i - 1))) begin fails++; $display("FAIL stream_rdata%0d: got %h expected %h", i, m0_bus.rdata, data_of(16'h0010 + 16'(i - 1))); end
            end
            step();
        end
        drive_m0(1'b0, 1'b0, 16'h0000, 8'h00);
        exp_q.push_back({1'b1, 1'b0, 16'h002C, 8'h00});
        sample();
        checks++; if (s_bus.addr !== 16'h002C || m1_bus.rdy !== 1'b1) begin fails++; $display("FAIL stream_handover: got addr=%h rdy=%b expected addr=002c rdy=1", s_bus.addr, m1_bus.rdy); end
        checks++; if (m0_bus.rdata !== 8'h33) begin fails++; $display("FAIL stream_last_rdata: got %h expected 33", m0_bus.rdata); end
        step();
        idle_all();
        sample();
        checks++; if (m1_bus.rdata !== 8'hCC || dp_owner !== 2'b10) begin fails++; $display("FAIL stream_m1_rdata: got %h owner=%b expected cc owner=10", m1_bus.rdata, dp_owner); end
        step();
    endtask

    task automatic test_stall;
        drive_m1(1'b1, 1'b0, 16'h8004, 8'h00, 1'b1);
        step();
        drive_m1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        drive_m0(1'b1, 1'b0, 16'h0005, 8'h00);
        sram_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            checks++; if (dp_owner !== 2'b10 || m0_bus.rdy !== 1'b0 || m1_bus.rdy !== 1'b0) begin fails++; $display("FAIL stall_hold%0d: got owner=%b rdy=%b%b expected owner=10 rdy=00", i, dp_owner, m1_bus.rdy, m0_bus.rdy); end
            step();
        end
        sram_rdy = 1'b1;
        sample();
        checks++; if (m1_bus.rdata !== 8'h44) begin fails++; $display("FAIL stall_rdata: got %h expected 44", m1_bus.rdata); end
        checks++; if (m0_bus.rdy !== 1'b1 || s_bus.addr !== 16'h0005) begin fails++; $display("FAIL stall_resume: got rdy=%b addr=%h expected rdy=1 addr=0005", m0_bus.rdy, s_bus.addr); end
        step();
        idle_all();
        sample();
        checks++; if (m0_bus.rdata !== 8'h55 || dp_owner !== 2'b01) begin fails++; $display("FAIL stall_m0_rdata: got %h owner=%b expected 55 owner=01", m0_bus.rdata, dp_owner); end
        step();
    endtask

    task automatic test_reset_mid;
        drive_m0(1'b1, 1'b0, 16'h0007, 8'h00);
        step();
        drive_m0(1'b0, 1'b0, 16'h0000, 8'h00);
        sample();
        checks++; if (dp_owner !== 2'b01) begin fails++; $display("FAIL rst_pre_owner: got %b expected 01", dp_owner); end
        #2 res_n = 1'b0;
        #1;
        checks++; if (dp_owner !== 2'b00 || m0_bus.rdata !== 8'h00) begin fails++; $display("FAIL rst_async: got owner=%b rdata=%h expected owner=00 rdata=00", dp_owner, m0_bus.rdata); end
        step();
        res_n = 1'b1;
        drive_m0(1'b1, 1'b1, 16'h0009, 8'h99);
        drive_m1(1'b1, 1'b0, 16'h000A, 8'h00, 1'b1);
        sample();
        checks++; if (s_bus.addr !== 16'h0009 || m1_bus.rdy !== 1'b0) begin fails++; $display("FAIL rst_tie: got addr=%h m1_rdy=%b expected addr=0009 m1_rdy=0", s_bus.addr, m1_bus.rdy); end
        step();
        drive_m0(1'b0, 1'b0, 16'h0000, 8'h00);
        sample();
        checks++; if (s_bus.addr !== 16'h000A || dp_owner !== 2'b01) begin fails++; $display("FAIL rst_second: got addr=%h owner=%b expected addr=000a owner=01", s_bus.addr, dp_owner); end
        step();
        idle_all();
        sample();
        checks++; if (m1_bus.rdata !== 8'hAA) begin fails++; $display("FAIL rst_m1_rdata: got %h expected aa", m1_bus.rdata); end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_m0_writes();
        test_tie_from_reset();
        test_read_overlap();
        test_stream();
        test_stall();
        test_reset_mid();
        step();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
